// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode and
// funct fields, ALU control codes and the main-FSM-to-ALU-decoder operation selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  // Final state of every supported instruction; leaving one for FETCH retires it.
  function automatic logic retires(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: the main FSM picks add, sub or funct-driven operation and
// this block turns that plus the funct field into the 3-bit ALU code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] funct,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluControl = ALU_ADD;
          FN_SUB:  aluControl = ALU_SUB;
          FN_AND:  aluControl = ALU_AND;
          FN_OR:   aluControl = ALU_OR;
          FN_SLT:  aluControl = ALU_SLT;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j)
// with a retired-instruction counter.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            memReady,
  output logic            pcEn,
  output logic            irWrite,
  output logic            memWrite,
  output logic            regWrite,
  output logic            iord,
  output logic            aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic            regDst,
  output logic            memtoReg,
  output logic [1:0]      pcSrc,
  output logic [2:0]      aluControl,
  output logic [3:0]      state,
  output logic [CNTW-1:0] instrCount
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pc_write;
  logic            branch;
  logic [1:0]      alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_supported(funct) ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = memReady ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Illegal-op aborts from DECODE and recovery from unused codes do not count.
  always_comb begin
    cnt_d = cnt_q;
    if (retires(state_q) && (state_d == S_FETCH)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_comb begin
    pc_write = 1'b0;
    branch   = 1'b0;
    irWrite  = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    iord     = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    regDst   = 1'b0;
    memtoReg = 1'b0;
    pcSrc    = 2'b00;
    alu_op   = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        aluSrcB  = 2'b01;
        irWrite  = memReady;
        pc_write = memReady;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoReg = 1'b1;
        regWrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memWrite = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        pcSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIWB: regWrite = 1'b1;
      S_JUMP: begin
        pcSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluOp      (alu_op),
    .funct      (funct),
    .aluControl (aluControl)
  );

  assign pcEn       = pc_write | (branch & zero);
  assign state      = state_q;
  assign instrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction walks plus a randomized
// instruction stream checked against an instruction-level phase model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        memReady = 1'b1;
  logic        pcEn, irWrite, memWrite, regWrite, iord, aluSrcA, regDst, memtoReg;
  logic [1:0]  aluSrcB, pcSrc;
  logic [2:0]  aluControl;
  logic [3:0]  state;
  logic [31:0] instrCount;

  multicycle_controller #(.CNTW(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memReady(memReady), .pcEn(pcEn), .irWrite(irWrite), .memWrite(memWrite),
    .regWrite(regWrite), .iord(iord), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .regDst(regDst), .memtoReg(memtoReg), .pcSrc(pcSrc), .aluControl(aluControl),
    .state(state), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] ac_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;
  logic        rdy_q[$];
  int          rdy_random = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fn_index(input logic [5:0] f);
    for (int i = 0; i < 5; i++) if (fn_tab[i] == f) return i;
    return -1;
  endfunction

  // {pcEn,irWrite,memWrite,regWrite,iord,aluSrcA,aluSrcB,regDst,memtoReg,pcSrc,aluControl}
  function automatic logic [14:0] exp_outs(input int code, input logic [5:0] f,
                                           input logic z, input logic rdy);
    logic pe, ir, mw, rw, io, sa, rd, m2r;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    pe = 0; ir = 0; mw = 0; rw = 0; io = 0; sa = 0; rd = 0; m2r = 0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (code)
      0:    begin sb = 2'b01; ir = rdy; pe = rdy; end
      1:    sb = 2'b11;
      2, 9: begin sa = 1; sb = 2'b10; end
      3:    io = 1;
      4:    begin m2r = 1; rw = 1; end
      5:    begin io = 1; mw = 1; end
      6:    begin sa = 1; if (fn_index(f) >= 0) ac = ac_tab[fn_index(f)]; end
      7:    begin rd = 1; rw = 1; end
      8:    begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      10:   rw = 1;
      11:   begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, ir, mw, rw, io, sa, sb, rd, m2r, ps, ac};
  endfunction

  // Walks one instruction through its phase list; exp_cycles < 0 skips the latency check.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int exp_cycles);
    int   codes[$];
    bit   waits[$];
    bit   retire;
    int   idx, n;
    logic rdy;
    codes.push_back(0); waits.push_back(1);
    codes.push_back(1); waits.push_back(0);
    retire = 1;
    if (o == LW) begin
      codes.push_back(2); waits.push_back(0);
      codes.push_back(3); waits.push_back(1);
      codes.push_back(4); waits.push_back(0);
    end else if (o == SW) begin
      codes.push_back(2); waits.push_back(0);
      codes.push_back(5); waits.push_back(1);
    end else if (o == RT && fn_index(f) >= 0) begin
      codes.push_back(6); waits.push_back(0);
      codes.push_back(7); waits.push_back(0);
    end else if (o == BEQ) begin
      codes.push_back(8); waits.push_back(0);
    end else if (o == ADDI) begin
      codes.push_back(9); waits.push_back(0);
      codes.push_back(10); waits.push_back(0);
    end else if (o == JMP) begin
      codes.push_back(11); waits.push_back(0);
    end else begin
      retire = 0;
    end
    op = o; funct = f; zero = z;
    idx = 0; n = 0;
    while (idx < codes.size() && n < 60) begin
      if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
      else if (rdy_random != 0) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1'b1;
      memReady = rdy;
      @(negedge clk);
      chk({tag, "_state"}, 32'(state), 32'(codes[idx]));
      chk({tag, "_outs"},
          32'({pcEn, irWrite, memWrite, regWrite, iord, aluSrcA, aluSrcB,
               regDst, memtoReg, pcSrc, aluControl}),
          32'(exp_outs(codes[idx], f, z, rdy)));
      @(posedge clk); #1;
      n++;
      if (!waits[idx] || rdy) idx++;
    end
    chk({tag, "_done"}, 32'(idx), 32'(codes.size()));
    if (retire) exp_cnt = exp_cnt + 32'd1;
    chk({tag, "_count"}, instrCount, exp_cnt);
    chk({tag, "_end_state"}, 32'(state), 32'd0);
    if (exp_cycles >= 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    logic [5:0] ro, rf;
    memReady = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'({pcEn, irWrite, memWrite, regWrite, iord, aluSrcA, aluSrcB,
                           regDst, memtoReg, pcSrc, aluControl}),
        32'(exp_outs(0, 6'd0, 1'b0, 1'b1)));
    chk("reset_count", instrCount, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    run_instr("lw", LW, 6'd0, 1'b0, 5);
    run_instr("slt", RT, 6'b101010, 1'b0, 4);
    run_instr("bad_funct", RT, 6'b000111, 1'b0, 2);
    run_instr("beq_taken", BEQ, 6'd0, 1'b1, 3);
    run_instr("beq_not", BEQ, 6'd0, 1'b0, 3);
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    run_instr("sw_stall", SW, 6'd0, 1'b0, 7);
    run_instr("j", JMP, 6'd0, 1'b0, 3);
    run_instr("addi", ADDI, 6'd0, 1'b0, 4);
    run_instr("add", RT, 6'b100000, 1'b0, 4);
    run_instr("sub", RT, 6'b100010, 1'b1, 4);
    run_instr("and", RT, 6'b100100, 1'b0, 4);
    run_instr("or", RT, 6'b100101, 1'b0, 4);
    run_instr("sw", SW, 6'd0, 1'b0, 4);
    run_instr("bad_op", 6'b111111, 6'd0, 1'b0, 2);

    rdy_random = 1;
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 7))
        0: ro = LW;
        1: ro = SW;
        2, 3: ro = RT;
        4: ro = BEQ;
        5: ro = ADDI;
        6: ro = JMP;
        default: ro = 6'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) rf = 6'($urandom);
      else rf = fn_tab[$urandom_range(0, 4)];
      run_instr("rand", ro, rf, 1'($urandom), -1);
    end
    rdy_random = 0;

    // Abort a store while it is stalled in MEMWR.
    op = SW; funct = 6'd0; zero = 1'b0; memReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    memReady = 1'b0;
    @(negedge clk);
    chk("sw_hold_state", 32'(state), 32'd5);
    chk("sw_hold_memwrite", 32'(memWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_memwrite", 32'(memWrite), 32'd0);
    chk("abort_regwrite", 32'(regWrite), 32'd0);
    chk("abort_count", instrCount, 32'd0);
    exp_cnt = '0;
    @(posedge clk); #1;
    chk("abort_hold_state", 32'(state), 32'd0);
    reset = 1'b0;
    run_instr("lw_after_abort", LW, 6'd0, 1'b0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequences the multicycle MIPS datapath.
- Instructions supported: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
- A Moore FSM drives the datapath mux selects and write enables, and generates the 3-bit aluControl code for the shared ALU.
- Sits between the instruction register (op/funct fields), ALU zero flag, memory-ready handshake and datapath enables. Maintains a retired-instruction counter.

Parameters:
- CNTW, 32, width of retired-instruction counter instrCount.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  6  instr[31:26] from instruction register.
- funct  input  6  instr[5:0] from instruction register.
- zero  input  1  ALU zero flag.
- memReady  input  1  memory completes the current access this cycle.
- pcEn  output  1  PC load enable = (pcWrite & memReady-qualified) | (branch & zero).
- irWrite  output  1  instruction register load.
- memWrite  output  1  data memory write request.
- regWrite  output  1  register file write.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- aluSrcA  output  1  0=PC, 1=regA.
- aluSrcB  output  2  00=regB, 01=const 4, 10=signImm, 11=signImm<<2.
- regDst  output  1  0=rt, 1=rd.
- memtoReg  output  1  0=ALUOut, 1=memData.
- pcSrc  output  2  00=aluResult, 01=ALUOut, 10=jump target.
- aluControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  output  4  current state (debug).
- instrCount  output  CNTW  retired instructions, wraps modulo 2^CNTW.

Behaviour:
- Reset: clk/reset only; async reset forces state=FETCH and instrCount=0.
- Outputs decode combinationally from state (plus funct, zero and memReady where noted). Reset-time outputs are therefore FETCH values.
- States, encoding and transitions:
  - FETCH=0: holds until memReady=1, then → DECODE.
  - DECODE=1: dispatch on op:
    - 100011 or 101011 → MEMADR
    - 000000 → EXECUTE if funct ∈ {100000, 100010, 100100, 100101, 101010}, else → FETCH
    - 000100 → BRANCH
    - 001000 → ADDIEXEC
    - 000010 → JUMP
    - any other op → FETCH
  - MEMADR=2: → MEMRD if op=100011, else → MEMWR.
  - MEMRD=3: holds until memReady, then → MEMWB.
  - MEMWB=4: → FETCH.
  - MEMWR=5: holds until memReady, then → FETCH.
  - EXECUTE=6: → ALUWB.
  - ALUWB=7: → FETCH.
  - BRANCH=8: → FETCH.
  - ADDIEXEC=9: → ADDIWB.
  - ADDIWB=10: → FETCH.
  - JUMP=11: → FETCH.
  - Codes 12-15: → FETCH next cycle, all enables 0.
- Per-state outputs (all unlisted enables 0; selects 0; aluControl=010 unless stated):
  - FETCH: iord=0, aluSrcA=0, aluSrcB=01, pcSrc=00. irWrite=memReady, pcWrite=memReady.
  - DECODE: aluSrcA=0, aluSrcB=11.
  - MEMADR, ADDIEXEC: aluSrcA=1, aluSrcB=10.
  - MEMRD: iord=1.
  - MEMWR: iord=1, memWrite=1 for the whole state. Memory commits on the memReady cycle.
  - MEMWB: regDst=0, memtoReg=1, regWrite=1.
  - EXECUTE: aluSrcA=1, aluSrcB=00, aluControl from funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - ALUWB: regDst=1, regWrite=1.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluControl=110, pcSrc=01, branch=1. PC loads ALUOut only when zero=1.
  - ADDIWB: regWrite=1.
  - JUMP: pcSrc=10, pcWrite=1.
- Latency with memReady tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Each extra memReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- instrCount increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - It does not increment on DECODE→FETCH (illegal/unsupported op or funct) or on recovery from codes 12-15.
- Reset mid-instruction aborts immediately: no write enable asserts after reset rises. Counter clears.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (4-bit, encodings above);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - ALU control codes ALU_ADD/SUB/AND/OR/SLT.
- The ALU imports the same ALU codes.
- Sub-module alu_decoder: combinational aluOp[1:0] (00 add, 01 sub, 10 funct) + funct → aluControl. Unknown funct → 010.

Test Plan:
- Reset with memReady=1 → state=0, irWrite=1, pcEn=1, aluSrcB=01, aluControl=010, instrCount=0. Assert reset during MEMWR → state=0 asynchronously, memWrite=0.
- lw (op=100011), memReady=1 → states 0,1,2,3,4,0. regWrite=1 with memtoReg=1 only in state 4. instrCount=1 after 5 cycles.
- R-type slt (funct=101010) → aluControl=111 in EXECUTE, regDst=1 and regWrite=1 in ALUWB. funct=000111 → DECODE→FETCH, instrCount unchanged.
- beq with zero=1 → pcEn=1, pcSrc=01 in BRANCH. With zero=0 → pcEn=0. Both take 3 cycles.
- sw with memReady=0 for 3 cycles in MEMWR → state holds at 5 with memWrite=1. Exits the cycle after memReady=1; total 7 cycles.
- j then addi, memReady=1 → pcSrc=10 and pcEn=1 in JUMP. ADDIWB has regWrite=1, regDst=0, memtoReg=0. instrCount=2.
